// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared types and constants for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int TO_CNT_W = 16;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or above i_ptr, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic          o_found
);

    logic [2*N-1:0] w_shr;
    logic [2*N-1:0] w_shl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_first;

    // rotate so i_ptr sits at bit 0, isolate lowest set bit, rotate back
    assign w_shr   = {i_req, i_req} >> i_ptr;
    assign w_rot   = w_shr[N-1:0];
    assign w_first = w_rot & (~w_rot + 1'b1);
    assign w_shl   = {w_first, w_first} << i_ptr;
    assign o_pick  = w_shl[2*N-1:N];
    assign o_found = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet arbiter driving one FIFO write port with full backpressure.
// Optional idle-grant timeout enabled by defining FIFO_WR_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH     = 8,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int ID_WIDTH       = id_width(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_s_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
    input  logic                          i_fifo_full,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [ID_WIDTH-1:0]           o_grant_id,
    output logic                          o_busy,
    output logic                          o_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("fifo_wr_arbiter: illegal parameter value");
    end

    arb_state_t            r_state;
    arb_state_t            w_next;
    logic [NUM_REQ-1:0]    r_grant;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0]    w_pick;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_pick_id;
    logic [ID_WIDTH-1:0]   w_ptr_nxt;
    logic                  w_gvalid;
    logic                  w_glast;
    logic [DATA_WIDTH-1:0] w_gdata;
    logic                  w_acc;
    logic                  w_to;
    logic                  w_release;

    rr_picker #(.N(NUM_REQ), .IW(ID_WIDTH)) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_pick_id = '0;
        w_gdata   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) w_pick_id = ID_WIDTH'(i);
            if (r_grant[i]) w_gdata = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_gvalid  = |(i_req_valid & r_grant);
    assign w_glast   = |(i_req_last & r_grant);
    assign w_acc     = (r_state == GRANT) && w_gvalid && !i_fifo_full;
    assign w_release = (w_acc && w_glast) || w_to;
    assign w_ptr_nxt = (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_idle_cnt;

    // full-with-valid cycles neither count nor clear: only a missing valid counts
    always_ff @(posedge i_clk) begin
        if (!i_s_rst_n || r_state == IDLE || w_acc) r_idle_cnt <= '0;
        else if (!w_gvalid) r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    assign w_to = (r_state == GRANT) && !w_gvalid && (r_idle_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_s_rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_grant    <= w_pick;
                r_grant_id <= w_pick_id;
            end else if (w_release) begin
                r_grant    <= '0;
                r_grant_id <= '0;
                r_rr_ptr   <= w_ptr_nxt;
            end
        end
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_found ? GRANT : IDLE) : (w_release ? IDLE : GRANT);
    end

    always_comb begin
        o_busy         = (r_state == GRANT);
        o_req_ready    = (r_state == GRANT && !i_fifo_full) ? r_grant : '0;
        o_fifo_wr_en   = w_acc;
        o_fifo_wr_data = w_acc ? w_gdata : '0;
        o_grant        = r_grant;
        o_grant_id     = r_grant_id;
        o_timeout      = w_to;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench with per-requester beat sources and a depth-4 FIFO model.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_last;
    logic [3:0]  o_req_ready;
    logic        o_fifo_wr_en;
    logic [7:0]  o_fifo_wr_data;
    logic        i_fifo_full;
    logic [3:0]  o_grant;
    logic [1:0]  o_grant_id;
    logic        o_busy;
    logic        o_timeout;

    int checks = 0;
    int failures = 0;

    logic [7:0] sd [4][32];
    logic       sl [4][32];
    int         slen [4] = '{0, 0, 0, 0};
    int         spos [4] = '{0, 0, 0, 0};

    logic [7:0] wlog [$];
    logic [1:0] glog [$];
    logic       pbusy = 1'b0;

    logic bypass;
    logic fifo_rd;
    int   fcnt = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(5)) dut (
        .i_clk          (clk),
        .i_s_rst_n      (rst_n),
        .i_req_valid    (i_req_valid),
        .i_req_data     (i_req_data),
        .i_req_last     (i_req_last),
        .o_req_ready    (o_req_ready),
        .o_fifo_wr_en   (o_fifo_wr_en),
        .o_fifo_wr_data (o_fifo_wr_data),
        .i_fifo_full    (i_fifo_full),
        .o_grant        (o_grant),
        .o_grant_id     (o_grant_id),
        .o_busy         (o_busy),
        .o_timeout      (o_timeout)
    );

    for (genvar g = 0; g < 4; g++) begin : g_src
        assign i_req_valid[g]      = spos[g] < slen[g];
        assign i_req_data[g*8 +: 8] = sd[g][spos[g]];
        assign i_req_last[g]       = sl[g][spos[g]];
    end

    assign i_fifo_full = !bypass && (fcnt >= 4);

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (o_req_ready[k] && i_req_valid[k]) spos[k] <= spos[k] + 1;
        if (bypass) fcnt <= 0;
        else fcnt <= fcnt + (o_fifo_wr_en ? 1 : 0) - ((fifo_rd && fcnt > 0) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (o_fifo_wr_en) wlog.push_back(o_fifo_wr_data);
        if (o_busy && !pbusy) glog.push_back(o_grant_id);
        pbusy = o_busy;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        sd[k][slen[k]] = d;
        sl[k][slen[k]] = l;
        slen[k] = slen[k] + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int b;
    int gb;

    initial begin
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 32; j++) begin
                sd[k][j] = 8'h00;
                sl[k][j] = 1'b0;
            end
        rst_n = 1'b0;
        bypass = 1'b1;
        fifo_rd = 1'b0;
        tick;
        tick;
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_grant_id", 32'(o_grant_id), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_ready", 32'(o_req_ready), 0);
        chk("rst_wr_en", 32'(o_fifo_wr_en), 0);
        chk("rst_wr_data", 32'(o_fifo_wr_data), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        rst_n = 1'b1;

        // two 3-beat packets offered together: req0 then req2 after one bubble
        b = wlog.size();
        push(0, 8'hA0, 0); push(0, 8'hA1, 0); push(0, 8'hA2, 1);
        push(2, 8'hC0, 0); push(2, 8'hC1, 0); push(2, 8'hC2, 1);
        #1;
        chk("t1_c0_busy", 32'(o_busy), 0);
        chk("t1_c0_wr_en", 32'(o_fifo_wr_en), 0);
        tick;
        chk("t1_c1_grant", 32'(o_grant), 32'h1);
        chk("t1_c1_grant_id", 32'(o_grant_id), 0);
        chk("t1_c1_ready", 32'(o_req_ready), 32'h1);
        chk("t1_c1_wr_en", 32'(o_fifo_wr_en), 1);
        chk("t1_c1_data", 32'(o_fifo_wr_data), 32'hA0);
        tick; tick; tick;
        chk("t1_bubble_busy", 32'(o_busy), 0);
        chk("t1_bubble_wr_en", 32'(o_fifo_wr_en), 0);
        tick;
        chk("t1_c5_grant", 32'(o_grant), 32'h4);
        chk("t1_c5_grant_id", 32'(o_grant_id), 2);
        chk("t1_c5_data", 32'(o_fifo_wr_data), 32'hC0);
        tick; tick; tick;
        chk("t1_end_busy", 32'(o_busy), 0);
        chk("t1_rr_ptr", 32'(dut.r_rr_ptr), 3);
        chk("t1_count", 32'(wlog.size() - b), 6);
        begin
            logic [7:0] e1 [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
            for (int i = 0; i < 6; i++) chk($sformatf("t1_w%0d", i), 32'(wlog[b + i]), 32'(e1[i]));
        end

        // reset restarts round robin at 0; four requesters, two 1-beat packets each
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        b = wlog.size();
        gb = glog.size();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++) push(k, 8'(k * 16 + p), 1);
        for (int i = 0; i < 15; i++) tick;
        chk("t2_c15_busy", 32'(o_busy), 1);
        chk("t2_c15_grant_id", 32'(o_grant_id), 3);
        chk("t2_c15_data", 32'(o_fifo_wr_data), 32'h31);
        tick;
        chk("t2_end_busy", 32'(o_busy), 0);
        chk("t2_count", 32'(wlog.size() - b), 8);
        chk("t2_gcount", 32'(glog.size() - gb), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_w%0d", i), 32'(wlog[b + i]), 32'((i % 4) * 16 + i / 4));
            chk($sformatf("t2_g%0d", i), 32'(glog[gb + i]), 32'(i % 4));
        end

        // req1 6-beat packet into a depth-4 FIFO; req3 waits with foreign data
        bypass = 1'b0;
        b = wlog.size();
        for (int i = 0; i < 6; i++) push(1, 8'(8'hD0 + i), i == 5);
        push(3, 8'hEE, 0); push(3, 8'hE1, 0); push(3, 8'hE2, 1);
        tick;
        chk("t3_c1_grant", 32'(o_grant), 32'h2);
        chk("t3_c1_ready", 32'(o_req_ready), 32'h2);
        chk("t3_c1_data", 32'(o_fifo_wr_data), 32'hD0);
        tick; tick; tick; tick;
        chk("t3_full_busy", 32'(o_busy), 1);
        chk("t3_full_grant", 32'(o_grant), 32'h2);
        chk("t3_full_ready", 32'(o_req_ready), 0);
        chk("t3_full_wr_en", 32'(o_fifo_wr_en), 0);
        tick;
        chk("t3_full2_ready", 32'(o_req_ready), 0);
        fifo_rd = 1'b1;
        tick;
        chk("t3_drain_wr_en", 32'(o_fifo_wr_en), 1);
        chk("t3_drain_data", 32'(o_fifo_wr_data), 32'hD4);
        tick;
        fifo_rd = 1'b0;
        chk("t3_last_data", 32'(o_fifo_wr_data), 32'hD5);
        tick;
        bypass = 1'b1;
        chk("t3_end_busy", 32'(o_busy), 0);
        chk("t3_count", 32'(wlog.size() - b), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_w%0d", i), 32'(wlog[b + i]), 32'(8'hD0 + i));

        // reset for one cycle while req3 holds the grant
        tick;
        chk("t4_grant3", 32'(o_grant), 32'h8);
        chk("t4_data", 32'(o_fifo_wr_data), 32'hEE);
        rst_n = 1'b0;
        push(0, 8'hF0, 1);
        tick;
        chk("t4_rst_grant", 32'(o_grant), 0);
        chk("t4_rst_busy", 32'(o_busy), 0);
        chk("t4_rst_ready", 32'(o_req_ready), 0);
        chk("t4_rst_wr_en", 32'(o_fifo_wr_en), 0);
        chk("t4_rst_grant_id", 32'(o_grant_id), 0);
        rst_n = 1'b1;
        tick;
        chk("t4_after_grant", 32'(o_grant), 32'h1);
        chk("t4_after_data", 32'(o_fifo_wr_data), 32'hF0);
        tick; tick;
        chk("t4_resume_grant", 32'(o_grant), 32'h8);
        chk("t4_resume_data", 32'(o_fifo_wr_data), 32'hE1);
        tick; tick;
        chk("t4_end_busy", 32'(o_busy), 0);
        chk("t4_timeout_low", 32'(o_timeout), 0);

`ifdef FIFO_WR_ARB_TIMEOUT_EN
        push(1, 8'h51, 0);
        push(2, 8'h62, 1);
        tick;
        chk("t5_grant", 32'(o_grant), 32'h2);
        chk("t5_data", 32'(o_fifo_wr_data), 32'h51);
        tick; tick; tick; tick;
        chk("t5_pre_timeout", 32'(o_timeout), 0);
        chk("t5_pre_busy", 32'(o_busy), 1);
        tick;
        chk("t5_timeout", 32'(o_timeout), 1);
        tick;
        chk("t5_post_timeout", 32'(o_timeout), 0);
        chk("t5_post_busy", 32'(o_busy), 0);
        tick;
        chk("t5_next_grant", 32'(o_grant), 32'h4);
        chk("t5_next_data", 32'(o_fifo_wr_data), 32'h62);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one synchronous FIFO write port between NUM_REQ packet requesters.
- Arbitration is round-robin; the grant is held for a whole packet, from the first beat to the beat with last set.
- Sits directly in front of the FIFO write side and drives its write enable and write data.
- Uses the FIFO full flag as backpressure, so a full FIFO is never written.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- DATA_WIDTH, 8: beat width; must equal the FIFO data width.
- ID_WIDTH, $clog2(NUM_REQ): derived localparam; width of the grant id.
- TIMEOUT_CYCLES, 64: idle-cycle limit for the optional timeout; legal range 1..65535.

Ports:
- i_clk  in  1  clock
- i_s_rst_n  in  1  synchronous reset, active-low
- i_req_valid  in  NUM_REQ  per-requester beat valid
- i_req_data  in  NUM_REQ*DATA_WIDTH  flattened beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_req_last  in  NUM_REQ  last beat of packet
- o_req_ready  out  NUM_REQ  per-requester ready
- o_fifo_wr_en  out  1  to FIFO i_wr_en
- o_fifo_wr_data  out  DATA_WIDTH  to FIFO i_wr_data
- i_fifo_full  in  1  from FIFO o_full
- o_grant  out  NUM_REQ  one-hot current grant; all zero when idle
- o_grant_id  out  ID_WIDTH  binary index of the current grant
- o_busy  out  1  high while in GRANT
- o_timeout  out  1  one-cycle pulse on forced release (optional feature)

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_s_rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE; rr_ptr = 0.
  - o_grant = 0, o_grant_id = 0, o_busy = 0, o_timeout = 0.
  - o_req_ready = 0, o_fifo_wr_en = 0.
  - o_fifo_wr_data: don't-care, driven 0.
- Reset mid-packet: the grant is dropped immediately and the partial packet is left in the FIFO. Flushing it is the caller's responsibility.
- State machine, IDLE:
  - Round-robin pick of the first requester k with i_req_valid[k]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - If one is found: register grant = k and go to GRANT on the next edge.
  - If none is valid: stay in IDLE.
  - No beat is accepted in IDLE, so there is a one-cycle arbitration bubble between packets.
- State machine, GRANT:
  - Ready is combinational: o_req_ready[g] = !i_fifo_full. All non-granted ready bits are 0.
  - Beat accepted when i_req_valid[g] && o_req_ready[g]. On acceptance: o_fifo_wr_en = 1 in the same cycle and o_fifo_wr_data = data of requester g. Zero latency, no registering.
  - Accepted beat with i_req_last[g]=1: return to IDLE next cycle and set rr_ptr = (g+1) mod NUM_REQ.
- FIFO full: ready is deasserted, the grant is held, no write occurs and no beat is lost. The requester must hold valid, data and last stable while not ready.
- Fairness:
  - A requester whose valid is high in IDLE is granted within NUM_REQ-1 packets of other requesters.
  - A single-beat packet (last on its first beat) occupies 2 cycles: IDLE plus GRANT.
- Width rules:
  - rr_ptr wrap uses an explicit compare to NUM_REQ-1, so non-power-of-2 NUM_REQ is legal.
  - o_grant_id is the binary encoding of o_grant.

Optional Feature:
- Macro: FIFO_WR_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter counts GRANT cycles with i_req_valid[g]=0.
  - The counter clears on any accepted beat and on entering GRANT.
  - FIFO-full cycles with valid high do not count.
  - When the counter reaches TIMEOUT_CYCLES: force return to IDLE, set rr_ptr = g+1, pulse o_timeout for 1 cycle.
- Not defined: o_timeout is tied 0 and no counter logic exists.

Decomposition:
- Package fifo_wr_arb_pkg holds:
  - the arb_state_t enum {IDLE, GRANT};
  - the ID_WIDTH derivation function;
  - the timeout counter width constant (16).
- Sub-module rr_picker:
  - purely combinational;
  - inputs: request vector and rr_ptr;
  - outputs: one-hot pick and a found flag.
  - It is reused later by the read-side scheduler.

Test Plan:
- NUM_REQ=4, requesters 0 and 2 each offer a 3-beat packet simultaneously after reset -> req0 packet written first (3 wr_en pulses), 1 bubble cycle, then req2 packet; rr_ptr=3 at the end.
- All 4 requesters continuously offer 1-beat packets for 8 packets -> grant order 0,1,2,3,0,1,2,3; each packet occupies exactly 2 cycles.
- FIFO (ADDR_WIDTH=2) fills mid-packet while req1 sends 6 beats with no reads -> ready drops after 4 writes, grant held; drain 2 words -> remaining 2 beats written; byte order matches the source.
- Reset asserted for 1 cycle during GRANT of req3 -> next cycle o_grant=0, o_busy=0, o_req_ready=0; the following arbitration starts from req0.
- With FIFO_WR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=5: req1 sends 1 beat without last, then drops valid -> o_timeout pulses 5 cycles later, returns to IDLE, waiting req2 is granted next.
- Valid on a non-granted requester during GRANT -> its ready stays 0 and o_fifo_wr_data never reflects its data.
